// File: rtl/game_pkg.sv
// Shared constants for the gravity-flip game: screen geometry, ground FSM
// state encoding and the default LFSR seed.
package game_pkg;

  localparam int SCREEN_W = 640;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SOLID = 2'd1,
    ST_GAP   = 2'd2
  } ground_state_t;

  localparam logic [15:0] LFSR_DEFAULT_SEED = 16'hACE1;

  // Fibonacci x^16 + x^14 + x^13 + x^11 + 1, shifting left, feedback into bit 0.
  function automatic logic [15:0] lfsr16_next(input logic [15:0] s);
    return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
  endfunction

endpackage

// File: rtl/lfsr16.sv
// 16-bit seeded Fibonacci LFSR; advances once per cycle with step high.
// A zero seed is replaced by the package default so the state never locks up.
module lfsr16
  import game_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        step,
  input  logic [15:0] seed,
  output logic [15:0] q
);

  logic [15:0] seed_eff;
  assign seed_eff = (seed == 16'h0000) ? LFSR_DEFAULT_SEED : seed;

  always_ff @(posedge clk) begin
    if (reset) begin
      q <= seed_eff;
    end else if (step) begin
      q <= lfsr16_next(q);
    end
  end

endmodule

// File: rtl/ground_scroller.sv
// One scrolling ground row: random solid/gap segments enter at x = WIDTH-1
// and shift toward x = 0 on every enabled tick, after a safe lead-in run.
module ground_scroller
  import game_pkg::*;
#(
  parameter int          WIDTH     = SCREEN_W,
  parameter logic [15:0] SEED      = LFSR_DEFAULT_SEED,
  parameter int          LEAD_IN   = 64,
  parameter int          MIN_SOLID = 24,
  parameter int          MIN_GAP   = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable_board,
  output logic [WIDTH-1:0] line_o,
  output logic [15:0]      distance_o
);

  if (WIDTH < 2) begin : g_bad_width
    $error("ground_scroller: WIDTH must be at least 2");
  end
  if (LEAD_IN < 2 || LEAD_IN > 256) begin : g_bad_lead
    $error("ground_scroller: LEAD_IN must be in [2, 256]");
  end
  if (MIN_GAP < 1 || MIN_GAP + 7 > 255) begin : g_bad_gap
    $error("ground_scroller: MIN_GAP + 7 must fit in 8 bits and MIN_GAP >= 1");
  end
  if (MIN_SOLID < 1 || MIN_SOLID + 31 > 255) begin : g_bad_solid
    $error("ground_scroller: MIN_SOLID + 31 must fit in 8 bits and MIN_SOLID >= 1");
  end

  localparam logic [7:0] LEAD_REM  = 8'(LEAD_IN - 1);
  localparam logic [7:0] GAP_BASE  = 8'(MIN_GAP);
  localparam logic [7:0] SOLID_BASE = 8'(MIN_SOLID);

  ground_state_t state;
  logic [7:0]    rem;
  logic [15:0]   lfsr_q;
  logic          new_bit;
  logic          unused_lfsr;

  // The LFSR output is the value before this step's advance, as the length draw needs.
  lfsr16 u_lfsr (
    .clk   (clk),
    .reset (reset),
    .step  (enable_board),
    .seed  (SEED),
    .q     (lfsr_q)
  );

  assign unused_lfsr = ^lfsr_q[15:5];
  assign new_bit     = (state != ST_GAP);

  always_ff @(posedge clk) begin
    if (reset) begin
      line_o     <= '1;
      distance_o <= 16'd0;
      state      <= ST_IDLE;
      rem        <= 8'd0;
    end else if (enable_board) begin
      line_o <= {new_bit, line_o[WIDTH-1:1]};
      if (distance_o != 16'hFFFF) begin
        distance_o <= distance_o + 16'd1;
      end
      case (state)
        ST_IDLE: begin
          state <= ST_SOLID;
          rem   <= LEAD_REM;
        end
        ST_SOLID: begin
          if (rem > 8'd1) begin
            rem <= rem - 8'd1;
          end else begin
            state <= ST_GAP;
            rem   <= GAP_BASE + {5'd0, lfsr_q[2:0]};
          end
        end
        ST_GAP: begin
          if (rem > 8'd1) begin
            rem <= rem - 8'd1;
          end else begin
            state <= ST_SOLID;
            rem   <= SOLID_BASE + {3'd0, lfsr_q[4:0]};
          end
        end
        default: begin
          state <= ST_IDLE;
          rem   <= 8'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ground_scroller.sv
// Randomized-pause bench for ground_scroller against a segment-level model
// of the ground stream; a second instance with a zero seed rides alongside.
module tb_ground_scroller;
  import game_pkg::*;

  localparam int W = SCREEN_W;

  logic         clk = 1'b0;
  logic         reset;
  logic         enable_board;
  logic [W-1:0] line_a, line_z;
  logic [15:0]  dist_a, dist_z;

  ground_scroller #(.WIDTH(W), .SEED(16'hACE1)) dut (
    .clk(clk), .reset(reset), .enable_board(enable_board),
    .line_o(line_a), .distance_o(dist_a)
  );

  ground_scroller #(.WIDTH(W), .SEED(16'h0000)) dut_z (
    .clk(clk), .reset(reset), .enable_board(enable_board),
    .line_o(line_z), .distance_o(dist_z)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Model: a stream of segments; the next segment's length is drawn when the
  // current one emits its last column, using the LFSR value of that step.
  logic [W-1:0] m_row;
  logic [15:0]  m_lfsr;
  int           m_dist;
  bit           m_started;
  bit           m_bit;
  int           m_left;

  task automatic model_reset();
    m_row     = '1;
    m_lfsr    = 16'hACE1;
    m_dist    = 0;
    m_started = 0;
    m_bit     = 1;
    m_left    = 0;
  endtask

  task automatic model_step();
    bit nb;
    if (!m_started) begin
      m_started = 1;
      m_bit     = 1;
      m_left    = 64;
    end
    nb = m_bit;
    m_left--;
    if (m_left == 0) begin
      if (m_bit) begin
        m_bit  = 0;
        m_left = 6 + int'(m_lfsr % 8);
      end else begin
        m_bit  = 1;
        m_left = 24 + int'(m_lfsr % 32);
      end
    end
    m_row  = {nb, m_row[W-1:1]};
    m_lfsr = {m_lfsr[14:0], ^(m_lfsr & 16'hB400)};
    if (m_dist < 65535) m_dist++;
  endtask

  // Run lengths measured on the DUT's entering column.
  bit cur_bit;
  int run_len;
  bit first_run;

  task automatic track_reset();
    cur_bit   = 1;
    run_len   = 0;
    first_run = 1;
  endtask

  task automatic track(input bit b);
    if (b == cur_bit) begin
      run_len++;
    end else begin
      if (!cur_bit) begin
        check("gap_len_ok", W'(run_len >= 6 && run_len <= 13), W'(1));
      end else begin
        if (!first_run) check("solid_len_ok", W'(run_len >= 24 && run_len <= 55), W'(1));
        first_run = 0;
      end
      cur_bit = b;
      run_len = 1;
    end
  endtask

  int n;
  logic [W-1:0] hist [300];

  task automatic idle_cycle();
    enable_board = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic do_step();
    enable_board = 1'b1;
    @(posedge clk);
    #1;
    n++;
    model_step();
    check("line", line_a, m_row);
    check("dist", W'(dist_a), W'(m_dist));
    check("seed0_line", line_z, m_row);
    check("seed0_dist", W'(dist_z), W'(m_dist));
    track(line_a[W-1]);
  endtask

  task automatic maybe_pause();
    if ($urandom_range(0, 63) == 0) begin
      int k = $urandom_range(1, 3);
      for (int i = 0; i < k; i++) idle_cycle();
    end
  endtask

  initial begin
    bit paused = 0;
    reset        = 1'b1;
    enable_board = 1'b0;
    n = 0;
    model_reset();
    track_reset();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    repeat (10) idle_cycle();
    check("rst_line", line_a, '1);
    check("rst_dist", W'(dist_a), W'(0));
    check("rst_line_seed0", line_z, '1);
    check("rst_dist_seed0", W'(dist_z), W'(0));

    // Lead-in: 64 solid columns, then the first gap column.
    for (int i = 0; i < 64; i++) do_step();
    check("leadin_line", line_a, '1);
    check("leadin_dist", W'(dist_a), W'(64));
    do_step();
    check("first_gap_col", W'(line_a[W-1]), W'(0));

    while (n < 300) begin
      maybe_pause();
      do_step();
    end
    for (int i = 0; i < 300; i++) hist[i] = 'x;

    // Reset with enable held high, then replay the first 300 steps.
    reset = 1'b1;
    model_reset();
    track_reset();
    n = 0;
    enable_board = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    check("mid_rst_line", line_a, '1);
    check("mid_rst_dist", W'(dist_a), W'(0));
    while (n < 300) begin
      do_step();
      hist[n-1] = m_row;
      check("replay", line_a, hist[n-1]);
    end

    while (n < 2000) begin
      maybe_pause();
      do_step();
      if (!paused && n >= 1000 && line_a[W-1] == 1'b0 && m_bit == 1'b0) begin
        paused = 1;
        for (int i = 0; i < 50; i++) idle_cycle();
        check("pause_line", line_a, m_row);
        check("pause_dist", W'(dist_a), W'(m_dist));
      end
    end
    check("pause_taken", W'(paused), W'(1));

    while (n < 65600) begin
      maybe_pause();
      do_step();
    end
    check("sat_dist", W'(dist_a), W'(16'hFFFF));
    do_step();
    check("sat_hold", W'(dist_a), W'(16'hFFFF));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout got=%0d exp=%0d", n, 65601);
    $fatal(1, "timeout");
  end

endmodule
